// File: rtl/mult_drum_pkg.sv
// mult_drum_pkg: shared exponent classes, status flags and bias helper for the DRUM multiplier
package mult_drum_pkg;

    // Operand-pair classification made once in S1 and carried down the pipe
    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_SPECIAL
    } exp_cls_t;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } flags_t;

    // IEEE-style exponent bias for a given exponent width
    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/mult_drum_pipe_if.sv
// mult_drum_pipe_if: operand/result handshake bundle; MULT_DRUM_EXACT_MODE_EN adds exact_mode
interface mult_drum_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_operand;
    logic [W-1:0] b_operand;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         Exception;
    logic         Overflow;
    logic         Underflow;
`ifdef MULT_DRUM_EXACT_MODE_EN
    logic         exact_mode;
`endif

    modport master (
        output in_valid, a_operand, b_operand, out_ready,
`ifdef MULT_DRUM_EXACT_MODE_EN
        output exact_mode,
`endif
        input  in_ready, out_valid, result, Exception, Overflow, Underflow
    );

    modport slave (
        input  in_valid, a_operand, b_operand, out_ready,
`ifdef MULT_DRUM_EXACT_MODE_EN
        input  exact_mode,
`endif
        output in_ready, out_valid, result, Exception, Overflow, Underflow
    );

endinterface

// File: rtl/drum_trunc.sv
// drum_trunc: keeps the top K bits of a significand, forcing the LSB when any dropped bit is set
module drum_trunc #(
    parameter int SIG_W = 24,
    parameter int K     = 8
) (
    input  logic [SIG_W-1:0] sig,
    output logic [K-1:0]     seg
);

    generate
        if (K == SIG_W) begin : g_full
            assign seg = sig;
        end else begin : g_drum
            assign seg = sig[SIG_W-1 -: K] | K'(|sig[SIG_W-K-1:0]);
        end
    endgenerate

endmodule

// File: rtl/mult_drum_pipe.sv
// mult_drum_pipe: 3-stage DRUM-K floating-point multiplier with a global stall
// Optional macro MULT_DRUM_EXACT_MODE_EN adds a per-operation exact_mode using full significands.
module mult_drum_pipe
    import mult_drum_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int K     = 8
) (
    input logic             clk,
    input logic             rst_n,
    mult_drum_pipe_if.slave bus
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int XW    = EXP_W + 2;
`ifdef MULT_DRUM_EXACT_MODE_EN
    localparam int M     = SIG_W;
`else
    localparam int M     = K;
`endif
    localparam logic signed [XW-1:0] BIAS_X  = XW'(exp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 2);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(1);

    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic signed [XW-1:0] exp;
        exp_cls_t             cls;
        logic [M-1:0]         a;
        logic [M-1:0]         b;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic signed [XW-1:0] exp;
        exp_cls_t             cls;
        logic [2*M-1:0]       prod;
    } s2_t;

    s1_t                  s1_d, s1_q;
    s2_t                  s2_d, s2_q;
    logic                 out_valid_d, out_valid_q;
    logic [W-1:0]         result_d, result_q;
    flags_t               flags_d, flags_q;

    logic                 advance;
    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [SIG_W-1:0]     a_sig, b_sig;
    logic [K-1:0]         a_seg, b_seg;
    logic [M-1:0]         a_op, b_op;
    exp_cls_t             in_cls;
    logic                 hi;
    logic [2*M-1:0]       norm;
    logic [2*M-2+MAN_W:0] ext;
    logic [MAN_W-1:0]     man;
    logic signed [XW-1:0] exp_f;
    logic                 ovf, unf;
    logic [W-1:0]         inf_res, zero_res;
    logic                 unused_bits;

    assign advance       = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.Exception = flags_q.exception;
    assign bus.Overflow  = flags_q.overflow;
    assign bus.Underflow = flags_q.underflow;

    assign a_exp = bus.a_operand[W-2 -: EXP_W];
    assign b_exp = bus.b_operand[W-2 -: EXP_W];
    assign a_sig = {1'b1, bus.a_operand[MAN_W-1:0]};
    assign b_sig = {1'b1, bus.b_operand[MAN_W-1:0]};

    drum_trunc #(.SIG_W(SIG_W), .K(K)) u_trunc_a (.sig(a_sig), .seg(a_seg));
    drum_trunc #(.SIG_W(SIG_W), .K(K)) u_trunc_b (.sig(b_sig), .seg(b_seg));

    // S1: choose multiplier operands, classify exponents and form the biased exponent sum
    always_comb begin
`ifdef MULT_DRUM_EXACT_MODE_EN
        a_op = bus.exact_mode ? a_sig : M'(a_seg) << (M - K);
        b_op = bus.exact_mode ? b_sig : M'(b_seg) << (M - K);
`else
        a_op = a_seg;
        b_op = b_seg;
`endif
        in_cls = (&a_exp || &b_exp) ? CLS_SPECIAL :
                 (a_exp == '0 || b_exp == '0) ? CLS_ZERO : CLS_NORMAL;
        s1_d = s1_q;
        if (advance) begin
            s1_d.valid = bus.in_valid;
            s1_d.sign  = bus.a_operand[W-1] ^ bus.b_operand[W-1];
            s1_d.exp   = XW'(a_exp) + XW'(b_exp) - BIAS_X;
            s1_d.cls   = in_cls;
            s1_d.a     = a_op;
            s1_d.b     = b_op;
        end
    end

    // S2: segment multiply, sideband carried alongside
    always_comb begin
        s2_d = s2_q;
        if (advance) begin
            s2_d.valid = s1_q.valid;
            s2_d.sign  = s1_q.sign;
            s2_d.exp   = s1_q.exp;
            s2_d.cls   = s1_q.cls;
            s2_d.prod  = s1_q.a * s1_q.b;
        end
    end

    // S3: normalise on the product MSB, left-align the fraction, then resolve special cases and flags
    always_comb begin
        hi          = s2_q.prod[2*M-1];
        norm        = hi ? s2_q.prod : s2_q.prod << 1;
        ext         = {norm[2*M-2:0], {MAN_W{1'b0}}};
        man         = ext[2*M-2+MAN_W -: MAN_W];
        unused_bits = ^{ext[2*M-2:0], norm[2*M-1]};
        exp_f       = s2_q.exp + XW'(hi);
        inf_res     = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        zero_res    = {s2_q.sign, {(W-1){1'b0}}};
        ovf         = s2_q.cls == CLS_NORMAL && exp_f > EXP_MAX;
        unf         = s2_q.cls == CLS_NORMAL && exp_f < EXP_MIN;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = s2_q.valid;
            result_d    = s2_q.cls == CLS_SPECIAL ? inf_res :
                          (s2_q.cls == CLS_ZERO || unf) ? zero_res :
                          ovf ? inf_res : {s2_q.sign, exp_f[EXP_W-1:0], man};
            flags_d     = {s2_q.cls == CLS_SPECIAL, ovf, unf};
        end
    end

    // Pipeline registers; reset drops every in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_mult_drum_pipe.sv
// tb_mult_drum_pipe: directed and randomized checks of mult_drum_pipe against an arithmetic model
module tb_mult_drum_pipe;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    int          passed = 0;
    int          total = 0;
    int          popped = 0;
    int          idx;
    int          stale;
    logic        acc;
    logic [34:0] held;
    logic [34:0] exp_q[$];
    logic [31:0] sa_arr[5];
    logic [31:0] sb_arr[5];

    mult_drum_pipe_if #(.EXP_W(8), .MAN_W(23)) bus();

    mult_drum_pipe #(.EXP_W(8), .MAN_W(23), .K(K)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Reference: {Exception, Overflow, Underflow, result} from the DRUM rules in plain arithmetic
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        logic   s;
        longint sa, sb, ta, tb, p, m, unit;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255) return {3'b100, s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'h0};
        unit = longint'(1) << (24 - K);
        sa = longint'({1'b1, a[22:0]});
        sb = longint'({1'b1, b[22:0]});
        ta = sa / unit;
        tb = sb / unit;
        if (sa % unit != 0) ta = ta | 1;
        if (sb % unit != 0) tb = tb | 1;
        p = ta * tb;
        e = ea + eb - 127;
        if (p >= (longint'(1) << (2 * K - 1))) begin
            e = e + 1;
            m = (p << 23) >> (2 * K - 1);
        end else begin
            m = (p << 23) >> (2 * K - 2);
        end
        m = m - (longint'(1) << 23);
        if (e > 254) return {3'b010, s, 8'hFF, 23'h0};
        if (e < 1) return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int         sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        e = sel == 0 ? 8'd0 : sel == 1 ? 8'hFF :
            sel == 2 ? 8'($urandom_range(1, 3)) :
            sel == 3 ? 8'($urandom_range(200, 254)) : 8'($urandom_range(90, 165));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    // One clock of scoreboarded traffic: retire the output first, then record any acceptance
    task automatic tick(output logic accepted);
        logic [34:0] want;
        accepted = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            check("sb nonempty", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("sb result", {bus.Exception, bus.Overflow, bus.Underflow, bus.result}, want);
                popped++;
            end
        end
        if (accepted) exp_q.push_back(model(bus.a_operand, bus.b_operand));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [2:0] f);
        int n;
        bus.a_operand = a;
        bus.b_operand = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 3);
        check({tag, " result"}, bus.result, r);
        check({tag, " flags"}, {bus.Exception, bus.Overflow, bus.Underflow}, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_operand = '0;
        bus.b_operand = '0;
        bus.out_ready = 1'b0;
`ifdef MULT_DRUM_EXACT_MODE_EN
        bus.exact_mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset result", bus.result, 0);
        check("reset flags", {bus.Exception, bus.Overflow, bus.Underflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);

        run_one("2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
        run_one("1.5x-2.5", 32'h3FC00000, 32'hC0200000, 32'hC0700000, 3'b000);
        run_one("drum trunc", 32'h3FFFFFFF, 32'h3F800000, 32'h3FFF0000, 3'b000);
        run_one("inf x inf", 32'h7F800000, 32'h7F800000, 32'h7F800000, 3'b100);
        run_one("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
        run_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
        run_one("neg x zero", 32'hC1526666, 32'h00000000, 32'h80000000, 3'b000);

        for (int i = 0; i < 5; i++) begin
            sa_arr[i] = rand_op();
            sb_arr[i] = rand_op();
        end
        exp_q.delete();
        popped = 0;
        idx = 0;
        for (int t = 0; t < 40 && popped < 5; t++) begin
            bus.out_ready = !(t >= 3 && t < 7);
            bus.in_valid  = idx < 5;
            bus.a_operand = sa_arr[idx % 5];
            bus.b_operand = sb_arr[idx % 5];
            #1;
            if (t == 3) held = {bus.Exception, bus.Overflow, bus.Underflow, bus.result};
            if (t >= 3 && t < 7) begin
                check("stall in_ready", bus.in_ready, 0);
                check("stall out_valid", bus.out_valid, 1);
            end
            if (t > 3 && t < 7)
                check("stall hold", {bus.Exception, bus.Overflow, bus.Underflow, bus.result}, held);
            tick(acc);
            if (acc) idx++;
        end
        check("stall all popped", popped, 5);
        check("stall queue empty", exp_q.size(), 0);

        for (int t = 0; t < 300; t++) begin
            bus.in_valid  = $urandom_range(0, 9) < 7;
            bus.a_operand = rand_op();
            bus.b_operand = rand_op();
            bus.out_ready = $urandom_range(0, 9) < 7;
            #1;
            tick(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) tick(acc);
        check("random drain empty", exp_q.size(), 0);

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a_operand = rand_op();
            bus.b_operand = 32'h40000000;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("pre-reset out_valid", bus.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset out_valid", bus.out_valid, 0);
        check("async reset result", bus.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        check("no stale after reset", stale, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
